// File: rtl/sprom_loader.sv
// rtl/sprom_loader.sv - framed byte-stream loader writing DW-bit words into a sprom write port
// Optional trailing checksum byte when SPROM_LOADER_CSUM_EN is defined.
module sprom_loader #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          abort,
  output logic [AW-1:0] ext_addr,
  output logic [DW-1:0] ext_di,
  output logic          ext_we,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int BYTES = DW / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, WRITE,
`ifdef SPROM_LOADER_CSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  state_t        state;
  logic [7:0]    addr_lo;
  logic [AW-1:0] addr;
  logic [15:0]   cnt;
  logic [DW-1:0] word;
  logic [DW-1:0] word_next;
  logic [BW-1:0] byte_idx;
  logic          acc;
  logic          last_byte;

  assign acc       = s_valid && s_ready;
  assign last_byte = (byte_idx == BW'(BYTES - 1));

  always_comb begin
    word_next = word;
    word_next[8*byte_idx +: 8] = s_data;
  end

`ifdef SPROM_LOADER_CSUM_EN
  logic [7:0] csum;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_lo  <= '0;
      addr     <= '0;
      cnt      <= '0;
      word     <= '0;
      byte_idx <= '0;
      ext_addr <= '0;
      ext_di   <= '0;
      ext_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s_ready  <= 1'b1;
`ifdef SPROM_LOADER_CSUM_EN
      csum     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      ext_we <= 1'b0;
      done   <= 1'b0;
`ifdef SPROM_LOADER_CSUM_EN
      err_q  <= 1'b0;
`endif
      // A WRITE already on the port this cycle still lands; only later writes are dropped.
      if (abort && state != IDLE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        s_ready  <= 1'b1;
        byte_idx <= '0;
      end else begin
        case (state)
          IDLE: if (acc && s_data == 8'hA5) begin
            state    <= ADDR0;
            busy     <= 1'b1;
            byte_idx <= '0;
`ifdef SPROM_LOADER_CSUM_EN
            csum     <= '0;
`endif
          end
          ADDR0: if (acc) begin
            addr_lo <= s_data;
            state   <= ADDR1;
          end
          ADDR1: if (acc) begin
            addr  <= AW'({s_data, addr_lo});
            state <= LEN0;
          end
          LEN0: if (acc) begin
            cnt[7:0] <= s_data;
            state    <= LEN1;
          end
          LEN1: if (acc) begin
            cnt[15:8] <= s_data;
            if ({s_data, cnt[7:0]} != 16'd0) begin
              state <= DATA;
            end else begin
`ifdef SPROM_LOADER_CSUM_EN
              state   <= CSUM;
`else
              state   <= DONE;
              done    <= 1'b1;
              s_ready <= 1'b0;
`endif
            end
          end
          DATA: if (acc) begin
            word <= word_next;
`ifdef SPROM_LOADER_CSUM_EN
            csum <= csum + s_data;
`endif
            if (last_byte) begin
              state    <= WRITE;
              ext_we   <= 1'b1;
              ext_addr <= addr;
              ext_di   <= word_next;
              s_ready  <= 1'b0;
              byte_idx <= '0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          WRITE: begin
            addr <= addr + 1'b1;
            cnt  <= cnt - 16'd1;
            if (cnt == 16'd1) begin
`ifdef SPROM_LOADER_CSUM_EN
              state   <= CSUM;
              s_ready <= 1'b1;
`else
              state   <= DONE;
              done    <= 1'b1;
`endif
            end else begin
              state   <= DATA;
              s_ready <= 1'b1;
            end
          end
`ifdef SPROM_LOADER_CSUM_EN
          CSUM: if (acc) begin
            state   <= DONE;
            done    <= 1'b1;
            err_q   <= (s_data != csum);
            s_ready <= 1'b0;
          end
`endif
          DONE: begin
            state   <= IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprom_loader.sv
// tb/tb_sprom_loader.sv - randomized directed bench for sprom_loader with a frame-level reference model
module tb_sprom_loader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BYTES = DW / 8;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          abort = 1'b0;
  logic          s_ready;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_di;
  logic          ext_we;
  logic          busy;
  logic          done;
  logic          err;

  sprom_loader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .abort(abort), .ext_addr(ext_addr), .ext_di(ext_di), .ext_we(ext_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  logic [AW+DW-1:0] obs_w[$];
  logic [AW+DW-1:0] exp_w[$];
  logic             exp_err;
  bq_t              fr;
  logic [7:0]       dsum;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ext_we) begin
      obs_w.push_back({ext_addr, ext_di});
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (err) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  // Reference: scan for the sync byte, decode header, pack complete words little-endian.
  function automatic void model(input bq_t f);
    int i;
    int a;
    int n;
    logic [7:0] sum;
    logic [DW-1:0] w;
    exp_w.delete();
    exp_err = 1'b0;
    sum = 8'h00;
    i = 0;
    while (i < f.size() && f[i] != 8'hA5) i++;
    i++;
    if (i + 4 > f.size()) return;
    a = {f[i+1], f[i]};
    n = {f[i+3], f[i+2]};
    i += 4;
    for (int k = 0; k < n; k++) begin
      if (i + BYTES > f.size()) return;
      w = '0;
      for (int b = 0; b < BYTES; b++) begin
        w[8*b +: 8] = f[i+b];
        sum = sum + f[i+b];
      end
      i += BYTES;
      exp_w.push_back({AW'(a % (1 << AW)), w});
      a++;
    end
`ifdef SPROM_LOADER_CSUM_EN
    if (i < f.size()) exp_err = (f[i] != sum);
`endif
  endfunction

  task automatic start_frame(input int a, input int n);
    fr.delete();
    dsum = 8'h00;
    fr.push_back(8'hA5);
    fr.push_back(a[7:0]);
    fr.push_back(a[15:8]);
    fr.push_back(n[7:0]);
    fr.push_back(n[15:8]);
  endtask

  task automatic push_data(input logic [7:0] b);
    fr.push_back(b);
    dsum = dsum + b;
  endtask

  task automatic end_frame();
`ifdef SPROM_LOADER_CSUM_EN
    fr.push_back(dsum);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    s_data = b;
    s_valid = 1'b1;
    t = 0;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("s_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_all();
    foreach (fr[i]) send_byte(fr[i]);
  endtask

  task automatic clear_obs();
    obs_w.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic finish_frame(input string tag, input bit exp_done);
    int t;
    t = 0;
    while (exp_done && done_cnt == 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    model(fr);
    check({tag, "_wr_cnt"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), obs_w[i], exp_w[i]);
    check({tag, "_done_cnt"}, done_cnt, exp_done ? 1 : 0);
    check({tag, "_err"}, err_cnt, (exp_done && exp_err) ? 1 : 0);
    check({tag, "_busy"}, busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ext_we", ext_we, 1'b0);
    check("rst_ext_addr", ext_addr, '0);
    check("rst_ext_di", ext_di, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reference frame: two words at 0x010.
    clear_obs();
    start_frame(16'h0010, 2);
    for (int i = 1; i <= 8; i++) push_data(i[7:0]);
    end_frame();
    send_all();
    finish_frame("basic", 1'b1);
    check("basic_w0", obs_w.size() > 0 ? obs_w[0] : '0, {10'h010, 32'h04030201});
`ifndef SPROM_LOADER_CSUM_EN
    check("basic_done_after_we", done_cyc, last_we_cyc + 1);
`endif

    // Leading garbage is discarded.
    clear_obs();
    begin
      bq_t body;
      body = fr;
      fr = {8'h00, 8'hFF, 8'h5A};
      foreach (body[i]) fr.push_back(body[i]);
    end
    send_all();
    finish_frame("garbage", 1'b1);

    // Address wrap at the top of the ROM.
    clear_obs();
    start_frame(16'h03FF, 2);
    repeat (2 * BYTES) push_data(8'($urandom));
    end_frame();
    send_all();
    finish_frame("wrap", 1'b1);
    check("wrap_addr1", obs_w.size() > 1 ? obs_w[1][AW+DW-1:DW] : 10'h3FF, 10'h000);

    // Zero-length frame: done the cycle after the final byte, no writes.
    clear_obs();
    start_frame(16'h0020, 0);
    end_frame();
    send_all();
    @(negedge clk);
    check("zero_done_timing", done, 1'b1);
    finish_frame("zero", 1'b1);

    // Random frames, including a sync byte inside data.
    for (int r = 0; r < 4; r++) begin
      clear_obs();
      start_frame(int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(1, 3)));
      push_data(8'hA5);
      repeat ({fr[4], fr[3]} * BYTES - 1) push_data(8'($urandom));
      end_frame();
      send_all();
      finish_frame($sformatf("rand%0d", r), 1'b1);
    end

`ifdef SPROM_LOADER_CSUM_EN
    clear_obs();
    start_frame(16'h0010, 2);
    for (int i = 1; i <= 8; i++) push_data(i[7:0]);
    fr.push_back(dsum + 8'd1);
    send_all();
    finish_frame("bad_csum", 1'b1);
    check("bad_csum_flag", err_cnt, 1);
`endif

    // Abort after the 6th data byte: one word written, no done.
    clear_obs();
    start_frame(16'h0100, 2);
    repeat (6) push_data(8'($urandom));
    send_all();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_s_ready", s_ready, 1'b1);
    finish_frame("abort", 1'b0);

    // Reset asserted mid-data acts immediately.
    clear_obs();
    start_frame(16'h0040, 2);
    repeat (2) push_data(8'($urandom));
    send_all();
    #2 rst = 1'b0;
    #1;
    check("midrst_ext_we", ext_we, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_s_ready", s_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_idle_busy", busy, 1'b0);
    clear_obs();
    start_frame(16'h0041, 1);
    repeat (BYTES) push_data(8'($urandom));
    end_frame();
    send_all();
    finish_frame("after_rst", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
